// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and constants for the SDRAM CPU-port arbiter.
//   arb_state_e   : arbiter FSM states
//   TIMEOUT_RDATA : read data returned to a requester whose transaction
//                   timed out (only used when SDRAM_ARB_TIMEOUT_EN is defined)
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4,
    DRAIN     = 3'd5
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/sdram_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first requesting index after
// 'last', wrapping modulo N.
// Ports:
//   req   [N-1:0]          request vector
//   last  [$clog2(N)-1:0]  most recently granted index
//   grant [$clog2(N)-1:0]  selected index (0 when nothing requests)
//   valid                  at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] grant,
  output logic                 valid
);

  localparam int W = $clog2(N);

  logic [W-1:0] idx_s;

  // Walk the ring starting just after 'last'; the first hit wins.
  always_comb begin
    grant = {W{1'b0}};
    valid = 1'b0;
    idx_s = {W{1'b0}};
    for (int k = 1; k <= N; k++) begin
      idx_s = W'((int'(last) + k) % N);
      if (!valid && req[idx_s]) begin
        grant = idx_s;
        valid = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Shares the CPU-side port of the SDRAM interface between NUM_PORTS
// requesters. Round-robin arbitration, one transaction in flight, downstream
// command held stable until the interface reports completion.
//
// Ports:
//   cpu_clk, reset_n               clock, async active-low reset
//   req_ren/req_wen [NUM_PORTS]    per-port read/write request levels
//   req_addr/req_wdata [32*N]      per-port address / write data
//   req_bsv [4*N]                  per-port byte select
//   req_ack [NUM_PORTS]            one-cycle completion pulse
//   rd_data [32]                   read data, valid with req_ack
//   grant_id                       current / last granted port
//   mem_ren, mem_wen               one-cycle command to the interface
//   mem_addr, mem_wdata, mem_bsv   command payload, stable for the transaction
//   mem_rdata, mem_ready           interface response
//   timeout_err                    sticky watchdog flag
//
// Build option: define SDRAM_ARB_TIMEOUT_EN to enable the watchdog
// (TIMEOUT_CYCLES) and the DRAIN state; otherwise timeout_err is tied 0.
// -----------------------------------------------------------------------------
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         cpu_clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         req_ren,
  input  logic [NUM_PORTS-1:0]         req_wen,
  input  logic [NUM_PORTS*32-1:0]      req_addr,
  input  logic [NUM_PORTS*32-1:0]      req_wdata,
  input  logic [NUM_PORTS*4-1:0]       req_bsv,
  output logic [NUM_PORTS-1:0]         req_ack,
  output logic [31:0]                  rd_data,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         mem_ren,
  output logic                         mem_wen,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [3:0]                   mem_bsv,
  input  logic [31:0]                  mem_rdata,
  input  logic                         mem_ready,
  output logic                         timeout_err
);

  localparam int IDW = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ACK_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  arb_state_e           state_r, next_state_s;
  logic [NUM_PORTS-1:0] req_s;
  logic [IDW-1:0]       last_r, pick_s;
  logic                 pick_valid_s, start_s, is_read_r, timeout_s;

  assign req_s   = req_ren | req_wen;
  assign start_s = (state_r == IDLE) && pick_valid_s && mem_ready;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req   (req_s),
    .last  (last_r),
    .grant (pick_s),
    .valid (pick_valid_s)
  );

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_r;
  logic          timed_out_r, timeout_err_r, stalled_s;

  // Stalled means the current wait state would not advance this cycle.
  assign stalled_s   = ((state_r == WAIT_BUSY) && mem_ready) ||
                       ((state_r == WAIT_DONE) && !mem_ready);
  assign timeout_s   = stalled_s && (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_r;

  // Watchdog counter (restarts on every state entry) and sticky error flags.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r    <= {CW{1'b0}};
      timed_out_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if (next_state_s != state_r) begin
        wait_cnt_r <= {CW{1'b0}};
      end else if ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= {CW{1'b0}};
      end
      // timed_out_r steers RESPOND into DRAIN so the late completion from the
      // interface is absorbed before the next grant.
      if (timeout_s) begin
        timed_out_r   <= 1'b1;
        timeout_err_r <= 1'b1;
      end else if (state_r == RESPOND) begin
        timed_out_r <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign timeout_err      = 1'b0;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  // FSM state register.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) next_state_s = ISSUE;
        else         next_state_s = IDLE;
      end
      ISSUE: next_state_s = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout_s)       next_state_s = RESPOND;
        else if (!mem_ready) next_state_s = WAIT_DONE;
        else                 next_state_s = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (mem_ready || timeout_s) next_state_s = RESPOND;
        else                        next_state_s = WAIT_DONE;
      end
`ifdef SDRAM_ARB_TIMEOUT_EN
      RESPOND: begin
        if (timed_out_r) next_state_s = DRAIN;
        else             next_state_s = IDLE;
      end
      DRAIN: begin
        if (mem_ready) next_state_s = IDLE;
        else           next_state_s = DRAIN;
      end
`else
      RESPOND: next_state_s = IDLE;
`endif
      default: next_state_s = IDLE;
    endcase
  end

  // Grant capture, one-cycle command strobe, read-data capture and ack pulse.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r    <= IDW'(NUM_PORTS - 1);
      grant_id  <= {IDW{1'b0}};
      is_read_r <= 1'b0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_bsv   <= 4'h0;
      rd_data   <= 32'h0;
      req_ack   <= {NUM_PORTS{1'b0}};
    end else begin
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      req_ack <= {NUM_PORTS{1'b0}};
      if (start_s) begin
        last_r    <= pick_s;
        grant_id  <= pick_s;
        mem_addr  <= req_addr[32*int'(pick_s) +: 32];
        mem_wdata <= req_wdata[32*int'(pick_s) +: 32];
        mem_bsv   <= req_bsv[4*int'(pick_s) +: 4];
        // Read wins when both enables are high.
        is_read_r <= req_ren[pick_s];
        mem_ren   <= req_ren[pick_s];
        mem_wen   <= ~req_ren[pick_s];
      end
      if ((next_state_s == RESPOND) && (state_r != RESPOND)) begin
        req_ack <= ACK_ONE << grant_id;
      end
      if ((state_r == WAIT_DONE) && mem_ready) begin
        if (is_read_r) rd_data <= mem_rdata;
      end else if (timeout_s) begin
        rd_data <= TIMEOUT_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed self-checking bench for sdram_port_arbiter (2 ports). A small
// behavioural model of the SDRAM interface drops ready on each command and
// raises it again after busy_len cycles (or holds it low while stall is set).
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int NP = 2;
  localparam int TO = 16;

  logic              cpu_clk = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     req_ren, req_wen;
  logic [NP*32-1:0]  req_addr, req_wdata;
  logic [NP*4-1:0]   req_bsv;
  logic [NP-1:0]     req_ack;
  logic [31:0]       rd_data;
  logic [0:0]        grant_id;
  logic              mem_ren, mem_wen;
  logic [31:0]       mem_addr, mem_wdata;
  logic [3:0]        mem_bsv;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              timeout_err;

  sdram_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .cpu_clk     (cpu_clk),
    .reset_n     (reset_n),
    .req_ren     (req_ren),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_bsv     (req_bsv),
    .req_ack     (req_ack),
    .rd_data     (rd_data),
    .grant_id    (grant_id),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_bsv     (mem_bsv),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .timeout_err (timeout_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Interface model.
  int          busy_len = 6;
  int          busy_cnt;
  logic        stall = 1'b0;
  logic [31:0] model_rdata = 32'h0;
  int          ren_pulses = 0;
  int          wen_pulses = 0;

  always @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ready <= 1'b1;
      mem_rdata <= 32'h0;
      busy_cnt  <= 0;
    end else if (mem_ren || mem_wen) begin
      mem_ready <= 1'b0;
      busy_cnt  <= busy_len;
    end else if (!mem_ready && !stall) begin
      if (busy_cnt <= 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= model_rdata;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  always @(posedge cpu_clk) begin
    if (mem_ren) ren_pulses++;
    if (mem_wen) wen_pulses++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Raise one request at a negedge and wait (bounded) for its ack. Returns the
  // negedge count at the ack, the count at which mem_ready rose, and the number
  // of cycles from the command strobe onward where the payload differed.
  task automatic run_txn(input int port, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] bsv, input int budget,
                         output int lat, output int rise_at,
                         output int unstable, output logic got_ack);
    logic prev_ready;
    logic issued;
    req_addr[32*port +: 32] = addr;
    req_wdata[32*port +: 32] = wdata;
    req_bsv[4*port +: 4]    = bsv;
    req_ren[port] = rd;
    req_wen[port] = wr;
    lat = 0; rise_at = -1; unstable = 0; got_ack = 1'b0;
    prev_ready = mem_ready; issued = 1'b0;
    while (!got_ack && lat < budget) begin
      @(negedge cpu_clk);
      lat++;
      if (mem_ren || mem_wen) issued = 1'b1;
      if (issued && (mem_addr !== addr || mem_wdata !== wdata || mem_bsv !== bsv)) unstable++;
      if (!prev_ready && mem_ready && rise_at < 0) rise_at = lat;
      prev_ready = mem_ready;
      if (req_ack[port]) got_ack = 1'b1;
    end
    req_ren[port] = 1'b0;
    req_wen[port] = 1'b0;
  endtask

  int   lat, rise, unst, base_r, base_w, acks, cyc;
  logic ok;

  initial begin
    reset_n = 1'b0;
    req_ren = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_bsv = '0;
    repeat (3) @(negedge cpu_clk);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_req_ack", 32'(req_ack), 32'd0);
    check_eq("rst_mem_ren", 32'(mem_ren), 32'd0);
    check_eq("rst_mem_wen", 32'(mem_wen), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    @(negedge cpu_clk);

    // 1: port 0 read, 6 busy cycles.
    busy_len = 6; model_rdata = 32'h1234_5678;
    base_r = ren_pulses; base_w = wen_pulses;
    run_txn(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 100, lat, rise, unst, ok);
    check_eq("t1_ack", 32'(ok), 32'd1);
    check_eq("t1_ack_after_ready", 32'(lat - rise), 32'd1);
    check_eq("t1_grant", 32'(grant_id), 32'd0);
    check_eq("t1_rd_data", rd_data, 32'h1234_5678);
    check_eq("t1_ren_pulses", 32'(ren_pulses - base_r), 32'd1);
    check_eq("t1_wen_pulses", 32'(wen_pulses - base_w), 32'd0);
    repeat (2) @(negedge cpu_clk);

    // 2: port 1 write.
    busy_len = 3; model_rdata = 32'h5555_0000;
    base_r = ren_pulses; base_w = wen_pulses;
    run_txn(1, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 100, lat, rise, unst, ok);
    check_eq("t2_ack", 32'(ok), 32'd1);
    check_eq("t2_grant", 32'(grant_id), 32'd1);
    check_eq("t2_mem_bsv", 32'(mem_bsv), 32'h3);
    check_eq("t2_mem_addr", mem_addr, 32'h40);
    check_eq("t2_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    check_eq("t2_unstable", 32'(unst), 32'd0);
    check_eq("t2_rd_unchanged", rd_data, 32'h1234_5678);
    check_eq("t2_wen_pulses", 32'(wen_pulses - base_w), 32'd1);
    check_eq("t2_ren_pulses", 32'(ren_pulses - base_r), 32'd0);
    repeat (2) @(negedge cpu_clk);

    // 3: both ports request continuously; grants alternate 0,1,0,1,0,1.
    busy_len = 2;
    base_r = ren_pulses;
    req_addr = {32'h0000_2000, 32'h0000_1000};
    req_ren = 2'b11;
    acks = 0; cyc = 0;
    while (acks < 6 && cyc < 300) begin
      @(negedge cpu_clk);
      cyc++;
      if (|req_ack) begin
        check_eq($sformatf("t3_grant%0d", acks), 32'(grant_id), 32'(acks % 2));
        check_eq($sformatf("t3_ack%0d", acks), 32'(req_ack), 32'(1 << (acks % 2)));
        acks++;
        if (acks == 6) req_ren = 2'b00;
      end
    end
    check_eq("t3_ack_count", 32'(acks), 32'd6);
    repeat (10) @(negedge cpu_clk);
    check_eq("t3_ren_pulses", 32'(ren_pulses - base_r), 32'd6);

    // 4: port 0 read and write together -> read.
    busy_len = 1; model_rdata = 32'hCAFE_F00D;
    base_r = ren_pulses; base_w = wen_pulses;
    run_txn(0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 4'hF, 100, lat, rise, unst, ok);
    check_eq("t4_ack", 32'(ok), 32'd1);
    check_eq("t4_ren_pulses", 32'(ren_pulses - base_r), 32'd1);
    check_eq("t4_wen_pulses", 32'(wen_pulses - base_w), 32'd0);
    check_eq("t4_rd_data", rd_data, 32'hCAFE_F00D);
    repeat (2) @(negedge cpu_clk);

    // 5: reset in WAIT_DONE, then both ports request -> port 0 first.
    busy_len = 6; model_rdata = 32'h1111_2222;
    req_addr[31:0] = 32'h0000_0200; req_bsv[3:0] = 4'hF;
    req_ren[0] = 1'b1;
    repeat (5) @(negedge cpu_clk);
    reset_n = 1'b0;
    req_ren = 2'b00;
    #1;
    check_eq("t5_req_ack", 32'(req_ack), 32'd0);
    check_eq("t5_mem_ren", 32'(mem_ren), 32'd0);
    check_eq("t5_mem_addr", mem_addr, 32'd0);
    check_eq("t5_mem_bsv", 32'(mem_bsv), 32'd0);
    check_eq("t5_rd_data", rd_data, 32'd0);
    check_eq("t5_grant_id", 32'(grant_id), 32'd0);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    @(negedge cpu_clk);
    busy_len = 2; model_rdata = 32'h3333_4444;
    base_r = ren_pulses;
    req_addr[63:32] = 32'h0000_0500;
    req_ren[1] = 1'b1;
    run_txn(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 100, lat, rise, unst, ok);
    req_ren[1] = 1'b0;
    check_eq("t5_ack", 32'(ok), 32'd1);
    check_eq("t5_first_grant", 32'(grant_id), 32'd0);
    check_eq("t5_single_txn", 32'(ren_pulses - base_r), 32'd1);
    check_eq("t5_rd_data_after", rd_data, 32'h3333_4444);
    repeat (2) @(negedge cpu_clk);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // 6: mem_ready stuck low -> timeout ack, then no grant until ready returns.
    stall = 1'b1; busy_len = 1;
    run_txn(1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 100, lat, rise, unst, ok);
    check_eq("t6_ack", 32'(ok), 32'd1);
    check_eq("t6_latency", 32'(lat), 32'(3 + TO));
    check_eq("t6_rd_data", rd_data, 32'hDEAD_BEEF);
    check_eq("t6_timeout_err", 32'(timeout_err), 32'd1);
    base_r = ren_pulses;
    req_addr[31:0] = 32'h0000_0700;
    req_ren[0] = 1'b1;
    repeat (6) @(negedge cpu_clk);
    check_eq("t6_no_grant_in_drain", 32'(ren_pulses - base_r), 32'd0);
    stall = 1'b0;
    run_txn(0, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF, 100, lat, rise, unst, ok);
    check_eq("t6_ack_after_drain", 32'(ok), 32'd1);
    check_eq("t6_grant_after_drain", 32'(grant_id), 32'd0);
    check_eq("t6_err_sticky", 32'(timeout_err), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
